hdmi_video_sequencer: RTL

Generates raster timing for the TMDS output path and sequences each line's link periods: control, video preamble, video guard band and active video. Emits per-pixel mode and control words that drive the three lane TMDS encoders, plus pixel coordinates and a one-cycle-early pixel request to the pixel source. Sits between the pixel generator and the lane encoders / 10:1 serializer, and replaces hard-coded raster counters with a parameterised, enable-gated sequencer.

---
 rtl/hdmi_video_sequencer_pkg.sv | 16 +
 rtl/hdmi_video_sequencer_video_timing_counter.sv | 34 +++
 rtl/hdmi_video_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/hdmi_video_sequencer_pkg.sv
// hdmi_pkg: shared link-period types, sequencer states and TMDS code constants
package hdmi_pkg;
  typedef enum logic [1:0] {CONTROL = 2'd0, PREAMBLE = 2'd1, GUARD = 2'd2, VIDEO = 2'd3} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} seq_state_e;
  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
  localparam logic [9:0] VGB_LANE0 = 10'b1011001100;
  localparam logic [9:0] VGB_LANE1 = 10'b0100110011;
  localparam logic [9:0] VGB_LANE2 = 10'b1011001100;
  localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;
  function automatic logic [9:0] ctrl_code(input logic [1:0] cd);
    return cd == 2'b00 ? CTRL_CODE_00 : cd == 2'b01 ? CTRL_CODE_01 : cd == 2'b10 ? CTRL_CODE_10 : CTRL_CODE_11;
  endfunction
endpackage

// File: rtl/hdmi_video_sequencer_video_timing_counter.sv
// video_timing_counter: raster position counters with wrap, idle hold and end-of-frame flag
module video_timing_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [11:0] cx,
  output logic [11:0] cy,
  output logic [11:0] nx,
  output logic [11:0] ny,
  output logic        eof
);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  logic eol;
  // next raster position, wrapping at the end of each line and frame
  always_comb begin
    eol = cx == H_LAST;
    eof = eol && cy == V_LAST;
    nx = eol ? 12'd0 : cx + 12'd1;
    ny = eol ? (cy == V_LAST ? 12'd0 : cy + 12'd1) : cy;
  end
  // advance while running, park at the frame origin otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cx <= 12'd0;
      cy <= 12'd0;
    end else begin
      cx <= run ? nx : 12'd0;
      cy <= run ? ny : 12'd0;
    end
endmodule

// File: rtl/hdmi_video_sequencer.sv
// hdmi_video_sequencer: raster timing and TMDS link-period sequencing; define HDMI_VIDEO_GUARD_EN for preamble/guard periods
module hdmi_video_sequencer
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        pixclk,
  input  logic        pixrst_n,
  input  logic        enable,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        pix_req,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  mode,
  output logic [3:0]  ctl,
  output logic        line_start,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] HA    = 12'(H_ACTIVE);
  localparam logic [11:0] VA    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_LO = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_HI = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] VS_LO = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_HI = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
`ifdef HDMI_VIDEO_GUARD_EN
  localparam logic [11:0] VA_M1  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VT_M1  = 12'(V_TOTAL - 1);
  localparam logic [11:0] PRE_LO = 12'(H_TOTAL - 10);
  localparam logic [11:0] PRE_HI = 12'(H_TOTAL - 3);
  localparam logic [11:0] GRD_LO = 12'(H_TOTAL - 2);
  if (H_BP + H_SYNC + H_FP < 10 || H_BP < 10) begin : g_porch_check
    $error("hdmi_video_sequencer: blanking too short for preamble and guard band");
  end
  logic nla, pre, grd;
`endif
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
    $error("hdmi_video_sequencer: H_TOTAL and V_TOTAL must not exceed 4096");
  end
  seq_state_e state, state_d;
  logic run, eof, de_c, hs_c, vs_c, nde_c, pix_req_c;
  logic [11:0] cx, cy, nx, ny;
  mode_e mode_c;
  logic [3:0] ctl_c;
  assign run = state != IDLE;
  video_timing_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_counter (
    .clk(pixclk), .rst_n(pixrst_n), .run(run),
    .cx(cx), .cy(cy), .nx(nx), .ny(ny), .eof(eof)
  );
  // sequencer state register
  always_ff @(posedge pixclk or negedge pixrst_n)
    if (!pixrst_n) state <= IDLE;
    else state <= state_d;
  // start on enable, finish the frame when enable drops, resume seamlessly on re-enable
  always_comb begin
    state_d = state == IDLE ? (enable ? RUN : IDLE)
            : enable ? RUN
            : (state == DRAIN && eof) ? IDLE : DRAIN;
  end
  // decode the current raster position into link-period outputs
  always_comb begin
    de_c = cx < HA && cy < VA;
    hs_c = cx >= HS_LO && cx <= HS_HI;
    vs_c = cy >= VS_LO && cy <= VS_HI;
    nde_c = nx < HA && ny < VA;
    pix_req_c = nde_c && !(state == DRAIN && eof && !enable);
`ifdef HDMI_VIDEO_GUARD_EN
    nla = cy < VA_M1 || cy == VT_M1;
    pre = nla && cx >= PRE_LO && cx <= PRE_HI;
    grd = nla && cx >= GRD_LO;
    mode_c = de_c ? VIDEO : pre ? PREAMBLE : grd ? GUARD : CONTROL;
    ctl_c = pre ? CTL_VIDEO_PREAMBLE : 4'd0;
`else
    mode_c = de_c ? VIDEO : CONTROL;
    ctl_c = 4'd0;
`endif
  end
  // register outputs; idle presents the same quiescent values as reset
  always_ff @(posedge pixclk or negedge pixrst_n)
    if (!pixrst_n) begin
      x <= 12'd0;
      y <= 12'd0;
      pix_req <= 1'b0;
      de <= 1'b0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      mode <= CONTROL;
      ctl <= 4'd0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x <= run ? cx : 12'd0;
      y <= run ? cy : 12'd0;
      pix_req <= run && pix_req_c;
      de <= run && de_c;
      hsync <= (run && hs_c) ? SYNC_POL : ~SYNC_POL;
      vsync <= (run && vs_c) ? SYNC_POL : ~SYNC_POL;
      mode <= run ? mode_c : CONTROL;
      ctl <= run ? ctl_c : 4'd0;
      line_start <= run && cx == 12'd0;
      frame_start <= run && cx == 12'd0 && cy == 12'd0;
    end
endmodule
